// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot / Julia escape-time engine:
// FSM encoding, escape radius and fixed-point format helpers.
package mandelbrot_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK_MUL,
        S_EVAL,
        S_DONE
    } engine_state_t;

    // Escape when |z|^2 exceeds this value (real units, before fixed-point scaling)
    localparam int ESCAPE_MAG = 4;

    function automatic int frac_bits(input int width, input int int_bits);
        return width - int_bits;
    endfunction

endpackage

// File: rtl/radix4_serial_mult.sv
// Signed WIDTH x WIDTH multiplier, radix-4 Booth, two multiplier bits per cycle.
// A start pulse loads the operands; finished pulses once when product is valid.
module radix4_serial_mult
    #(parameter int WIDTH = 10)
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic signed [2*WIDTH-1:0] product,
    output logic                      finished
);

    localparam int STEPS = (WIDTH + 1) / 2;
    localparam int BW    = 2 * STEPS + 1;
    localparam int CW    = $clog2(STEPS + 1);

    logic signed [2*WIDTH-1:0] acc;
    logic signed [2*WIDTH-1:0] mcand;
    logic signed [2*WIDTH-1:0] pp;
    logic        [BW-1:0]      mplr;
    logic        [CW-1:0]      steps_left;
    logic                      busy;

    // Booth digit from the low three bits of the shifting multiplier
    always_comb begin
        pp = '0;
        case (mplr[2:0])
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand <<< 1;
            3'b100:         pp = -(mcand <<< 1);
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            mcand      <= '0;
            mplr       <= '0;
            steps_left <= '0;
            busy       <= 1'b0;
            finished   <= 1'b0;
        end else begin
            finished <= 1'b0;
            if (start) begin
                acc        <= '0;
                mcand      <= (2*WIDTH)'(a);
                mplr       <= {(2*STEPS)'(b), 1'b0};
                steps_left <= CW'(STEPS);
                busy       <= 1'b1;
            end else if (busy) begin
                acc        <= acc + pp;
                mcand      <= mcand <<< 2;
                mplr       <= {mplr[BW-1], mplr[BW-1], mplr[BW-1:2]};
                steps_left <= steps_left - CW'(1);
                if (steps_left == CW'(1)) begin
                    busy     <= 1'b0;
                    finished <= 1'b1;
                end
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/mandelbrot_iter_engine.sv
// Escape-time engine: iterates z <- z^2 + c on one accepted point using three
// shared-start serial multipliers, and reports iteration count and exit flags.
module mandelbrot_iter_engine
    import mandelbrot_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int INT_BITS   = 2,
    parameter int ITER_WIDTH = 8
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_pr,
    input  logic signed [WIDTH-1:0] in_pi,
    input  logic                    julia,
    input  logic signed [WIDTH-1:0] jc_r,
    input  logic signed [WIDTH-1:0] jc_i,
    input  logic [ITER_WIDTH-1:0]   max_iter,
    input  logic                    abort,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ITER_WIDTH-1:0]   iter_count,
    output logic                    escaped,
    output logic                    overflow
);

    localparam int FRAC = frac_bits(WIDTH, INT_BITS);
    localparam int PW   = 2 * WIDTH;
    localparam logic [PW:0] ESCAPE_R2 = (PW+1)'(ESCAPE_MAG) << (2 * FRAC);

    engine_state_t state, state_nx;

    logic signed [WIDTH-1:0]  zr, zi, cr, ci;
    logic signed [WIDTH-1:0]  op_r, op_i;
    logic [ITER_WIDTH-1:0]    count, limit;
    logic                     escaped_q, overflow_q, ready_q;
    logic                     mul_start, mul_done;
    logic                     unused_done_ii, unused_done_ri;
    logic signed [PW-1:0]     p_rr, p_ii, p_ri;

    logic        [PW:0]       mag2;
    logic signed [PW:0]       diff;
    logic signed [PW+1:0]     re_next, im_next;
    logic                     is_escape, at_limit, next_fits;

    radix4_serial_mult #(.WIDTH(WIDTH)) u_mul_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (mul_start),
        .a        (op_r),
        .b        (op_r),
        .product  (p_rr),
        .finished (mul_done)
    );

    radix4_serial_mult #(.WIDTH(WIDTH)) u_mul_ii (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (mul_start),
        .a        (op_i),
        .b        (op_i),
        .product  (p_ii),
        .finished (unused_done_ii)
    );

    radix4_serial_mult #(.WIDTH(WIDTH)) u_mul_ri (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (mul_start),
        .a        (op_r),
        .b        (op_i),
        .product  (p_ri),
        .finished (unused_done_ri)
    );

    // Squares are non-negative, so the magnitude sum is taken unsigned
    assign mag2      = {1'b0, p_rr} + {1'b0, p_ii};
    assign diff      = (PW+1)'(p_rr) - (PW+1)'(p_ii);
    assign re_next   = ((PW+2)'(diff) >>> FRAC) + (PW+2)'(cr);
    assign im_next   = ((PW+2)'(p_ri) >>> (FRAC - 1)) + (PW+2)'(ci);
    assign is_escape = (mag2 > ESCAPE_R2);
    assign at_limit  = (count == limit);
    assign next_fits = ((re_next[PW+1:WIDTH-1] == '0) || (&re_next[PW+1:WIDTH-1])) &&
                       ((im_next[PW+1:WIDTH-1] == '0) || (&im_next[PW+1:WIDTH-1]));

    // Operands come straight from the inputs on accept, otherwise from z'
    always_comb begin
        op_r = re_next[WIDTH-1:0];
        op_i = im_next[WIDTH-1:0];
        if (state == S_IDLE) begin
            op_r = julia ? in_pr : '0;
            op_i = julia ? in_pi : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        mul_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    mul_start = 1'b1;
                    state_nx  = S_CHECK_MUL;
                end
            end
            S_CHECK_MUL: begin
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (mul_done) begin
                    state_nx = S_EVAL;
                end
            end
            S_EVAL: begin
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (is_escape || at_limit || !next_fits) begin
                    state_nx = S_DONE;
                end else begin
                    mul_start = 1'b1;
                    state_nx  = S_CHECK_MUL;
                end
            end
            S_DONE: begin
                if (abort || out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zr         <= '0;
            zi         <= '0;
            cr         <= '0;
            ci         <= '0;
            limit      <= '0;
            count      <= '0;
            escaped_q  <= 1'b0;
            overflow_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        cr         <= julia ? jc_r : in_pr;
                        ci         <= julia ? jc_i : in_pi;
                        zr         <= julia ? in_pr : '0;
                        zi         <= julia ? in_pi : '0;
                        limit      <= max_iter;
                        count      <= '0;
                        escaped_q  <= 1'b0;
                        overflow_q <= 1'b0;
                    end
                end
                S_EVAL: begin
                    if (!abort) begin
                        if (is_escape) begin
                            escaped_q <= 1'b1;
                        end else if (!at_limit) begin
                            // An out-of-range update still counts as an iteration
                            count <= count + ITER_WIDTH'(1);
                            if (!next_fits) begin
                                escaped_q  <= 1'b1;
                                overflow_q <= 1'b1;
                            end else begin
                                zr <= re_next[WIDTH-1:0];
                                zi <= im_next[WIDTH-1:0];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (state == S_IDLE) && ready_q;
    assign out_valid  = (state == S_DONE);
    assign iter_count = count;
    assign escaped    = escaped_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_mandelbrot_iter_engine.sv
// Directed-vector bench for mandelbrot_iter_engine: a 12-bit (3 integer bits)
// and a 10-bit (2 integer bits) instance share stimulus, one active at a time.
module tb_mandelbrot_iter_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v12 = 1'b0, v10 = 1'b0;
    logic signed [11:0] in_pr = '0, in_pi = '0, jc_r = '0, jc_i = '0;
    logic        julia = 1'b0;
    logic [7:0]  max_iter = '0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;

    logic        r12, ov12, esc12, of12;
    logic [7:0]  cnt12;
    logic        r10, ov10, esc10, of10;
    logic [7:0]  cnt10;

    logic        cur = 1'b0;
    logic        m_ready, m_valid, m_esc, m_ovf;
    logic [7:0]  m_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mandelbrot_iter_engine #(.WIDTH(12), .INT_BITS(3), .ITER_WIDTH(8)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(v12), .in_ready(r12),
        .in_pr(in_pr), .in_pi(in_pi), .julia(julia), .jc_r(jc_r), .jc_i(jc_i),
        .max_iter(max_iter), .abort(abort), .out_valid(ov12), .out_ready(out_ready),
        .iter_count(cnt12), .escaped(esc12), .overflow(of12)
    );

    mandelbrot_iter_engine #(.WIDTH(10), .INT_BITS(2), .ITER_WIDTH(8)) dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(v10), .in_ready(r10),
        .in_pr(in_pr[9:0]), .in_pi(in_pi[9:0]), .julia(julia), .jc_r(jc_r[9:0]), .jc_i(jc_i[9:0]),
        .max_iter(max_iter), .abort(abort), .out_valid(ov10), .out_ready(out_ready),
        .iter_count(cnt10), .escaped(esc10), .overflow(of10)
    );

    always_comb begin
        m_ready = cur ? r10   : r12;
        m_valid = cur ? ov10  : ov12;
        m_esc   = cur ? esc10 : esc12;
        m_ovf   = cur ? of10  : of12;
        m_count = cur ? cnt10 : cnt12;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!m_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, int'(m_ready), 1);
    endtask

    task automatic accept(input bit use10, input bit jul, input int pr, input int pi,
                          input int jr, input int mi, input string tag);
        cur = use10;
        wait_ready(tag);
        julia    = jul;
        in_pr    = 12'(pr);
        in_pi    = 12'(pi);
        jc_r     = 12'(jr);
        jc_i     = '0;
        max_iter = 8'(mi);
        if (use10) v10 = 1'b1; else v12 = 1'b1;
        @(negedge clk);
        v10 = 1'b0;
        v12 = 1'b0;
    endtask

    task automatic run_point(input bit use10, input bit jul, input int pr, input int pi,
                             input int jr, input int mi, input int hold, input string tag,
                             input int ec, input int ee, input int eo);
        int n = 0;
        logic [7:0] c0;
        logic e0, o0;
        accept(use10, jul, pr, pi, jr, mi, tag);
        while (!m_valid && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, int'(m_valid), 1);
        check({tag, "_count"}, int'(m_count), ec);
        check({tag, "_esc"},   int'(m_esc),   ee);
        check({tag, "_ovf"},   int'(m_ovf),   eo);
        c0 = m_count;
        e0 = m_esc;
        o0 = m_ovf;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, int'(m_valid && m_count == c0 && m_esc == e0 && m_ovf == o0), 1);
            check({tag, "_hold_rdy"}, int'(m_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_released"}, int'(m_valid), 0);
    endtask

    initial begin
        int n;
        int seen;

        repeat (3) @(negedge clk);
        check("rst_ready", int'(r12), 0);
        check("rst_valid", int'(ov12), 0);
        check("rst_count", int'(cnt12), 0);
        check("rst_esc",   int'(esc12), 0);
        check("rst_ovf",   int'(of12), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_ready", int'(r12), 1);

        run_point(1'b0, 1'b0, 0,     0,   0,   20, 0,  "origin",   20, 0, 0);
        run_point(1'b0, 1'b0, 768,   0,   0,   20, 10, "c1p5",     2,  1, 0);
        run_point(1'b0, 1'b0, -1024, 0,   0,   15, 0,  "cm2_w12",  15, 0, 0);
        run_point(1'b1, 1'b0, -512,  0,   0,   20, 0,  "cm2_w10",  2,  1, 1);
        run_point(1'b0, 1'b1, 256,   0,   0,   0,  0,  "julia_in", 0,  0, 0);
        run_point(1'b0, 1'b1, 1280,  0,   0,   0,  0,  "julia_out", 0, 1, 0);
        run_point(1'b0, 1'b1, 256,   0,   512, 10, 0,  "julia_c1", 2,  1, 0);
        run_point(1'b0, 1'b0, 256,   256, 0,   20, 0,  "c_diag",   5,  1, 0);

        // Abort mid-run: must return to idle without producing a result
        accept(1'b0, 1'b0, 0, 0, 0, 200, "abort");
        repeat (20) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", int'(r12), 1);
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ov12) seen++;
        end
        check("abort_no_result", seen, 0);
        run_point(1'b0, 1'b0, 768, 0, 0, 20, 0, "after_abort", 2, 1, 0);

        // Asynchronous reset mid-run
        accept(1'b0, 1'b0, 0, 0, 0, 100, "arst");
        n = 0;
        while (cnt12 == 8'd0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("arst_running", int'(cnt12 != 8'd0), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", int'(cnt12), 0);
        check("arst_ready", int'(r12), 0);
        check("arst_valid", int'(ov12), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_point(1'b0, 1'b0, -1024, 0, 0, 3, 0, "after_arst", 3, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
